// File: rtl/robot_wall_follower.sv
// Left-wall-following controller.
// The raw head/left contact sensors are debounced, a four-state Moore FSM
// (search, rotate, follow, recover) runs on the filtered values, and the
// motion commands are registered from the decode of the next state.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SEARCH  | drive forward until the front sensor hits something
// ROTATE  | turn right until the wall is on the left; time out to SEARCH
// FOLLOW  | drive forward with the wall on the left
// RECOVER | wall lost on the left; turn left to find it, time out to SEARCH
module robot_wall_follower #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ROT_TIMEOUT     = 16,
    parameter int LOST_TIMEOUT    = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       head_i,
    input  logic       left_i,
    input  logic       fault_clear_i,
    output logic       avancar_o,
    output logic       girar_o,
    output logic       girar_esq_o,
    output logic [1:0] estado_o,
    output logic       rot_fault_o
);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'b00,
        S_ROTATE  = 2'b01,
        S_FOLLOW  = 2'b10,
        S_RECOVER = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROT_LAST  = CNT_W'(ROT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // index 0 is the head sensor, index 1 the left sensor
    logic [1:0]       raw;
    logic [1:0]       filt_q;
    logic [CNT_W-1:0] deb_cnt_q [2];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic             rot_timeout;

    logic             avancar_q, girar_q, girar_esq_q, rot_fault_q;

    logic             head_f, left_f;

    assign raw    = {left_i, head_i};
    assign head_f = filt_q[0];
    assign left_f = filt_q[1];

    // Debounce both sensors; filters keep running while the FSM is disabled.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            filt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    filt_q[i]    <= raw[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Next-state and timeout-counter logic; everything holds while disabled.
    always_comb begin
        state_d     = state_q;
        rot_cnt_d   = rot_cnt_q;
        lost_cnt_d  = lost_cnt_q;
        rot_timeout = 1'b0;
        if (enable_i) begin
            case (state_q)
                S_SEARCH: begin
                    if (head_f) begin
                        state_d   = S_ROTATE;
                        rot_cnt_d = '0;
                    end
                end
                S_ROTATE: begin
                    // finding the wall wins over a timeout on the same cycle
                    if (!head_f && left_f) begin
                        state_d = S_FOLLOW;
                    end else if (rot_cnt_q == ROT_LAST) begin
                        state_d     = S_SEARCH;
                        rot_timeout = 1'b1;
                    end else begin
                        rot_cnt_d = rot_cnt_q + CNT_ONE;
                    end
                end
                S_FOLLOW: begin
                    if (head_f) begin
                        state_d   = S_ROTATE;
                        rot_cnt_d = '0;
                    end else if (!left_f) begin
                        state_d    = S_RECOVER;
                        lost_cnt_d = '0;
                    end
                end
                S_RECOVER: begin
                    if (head_f) begin
                        state_d   = S_ROTATE;
                        rot_cnt_d = '0;
                    end else if (left_f) begin
                        state_d = S_FOLLOW;
                    end else if (lost_cnt_q == LOST_LAST) begin
                        state_d = S_SEARCH;
                    end else begin
                        lost_cnt_d = lost_cnt_q + CNT_ONE;
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end
    end

    // State register plus registered motion decode of the next state and the sticky fault.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_SEARCH;
            rot_cnt_q   <= '0;
            lost_cnt_q  <= '0;
            avancar_q   <= 1'b0;
            girar_q     <= 1'b0;
            girar_esq_q <= 1'b0;
            rot_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rot_cnt_q   <= rot_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
            avancar_q   <= enable_i && ((state_d == S_SEARCH) || (state_d == S_FOLLOW));
            girar_q     <= enable_i && (state_d == S_ROTATE);
            girar_esq_q <= enable_i && (state_d == S_RECOVER);
            // a new timeout beats a simultaneous clear
            if (rot_timeout) begin
                rot_fault_q <= 1'b1;
            end else if (fault_clear_i) begin
                rot_fault_q <= 1'b0;
            end
        end
    end

    assign avancar_o   = avancar_q;
    assign girar_o     = girar_q;
    assign girar_esq_o = girar_esq_q;
    assign estado_o    = state_q;
    assign rot_fault_o = rot_fault_q;

endmodule

// File: tb/tb_robot_wall_follower.sv
// Self-checking bench for robot_wall_follower: a cycle model pushes the
// expected outputs for each edge into a queue, popped and compared after the
// edge, plus directed checks of the key latencies and boundaries.
module tb_robot_wall_follower;

    localparam int DEB  = 4;
    localparam int ROT  = 16;
    localparam int LOST = 8;

    logic       clock, reset, enable, head, left, fault_clear;
    logic       avancar, girar, girar_esq, rot_fault;
    logic [1:0] estado;

    robot_wall_follower #(
        .DEBOUNCE_CYCLES(DEB),
        .ROT_TIMEOUT    (ROT),
        .LOST_TIMEOUT   (LOST),
        .CNT_W          (8)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .enable_i     (enable),
        .head_i       (head),
        .left_i       (left),
        .fault_clear_i(fault_clear),
        .avancar_o    (avancar),
        .girar_o      (girar),
        .girar_esq_o  (girar_esq),
        .estado_o     (estado),
        .rot_fault_o  (rot_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0] est;
        logic       av;
        logic       gr;
        logic       ge;
        logic       rf;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    int m_st = 0, m_rc = 0, m_lc = 0, m_hcnt = 0, m_lcnt = 0;
    bit m_hf = 0, m_lf = 0, m_rf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs and queue its outputs.
    task automatic model_edge(input bit rst, input bit en, input bit h, input bit l, input bit fc);
        int  ns;
        bit  to;
        exp_t e;
        if (rst) begin
            m_st = 0; m_rc = 0; m_lc = 0; m_hcnt = 0; m_lcnt = 0;
            m_hf = 0; m_lf = 0; m_rf = 0;
            e = '0;
        end else begin
            ns = m_st;
            to = 0;
            if (en) begin
                case (m_st)
                    0: if (m_hf) begin ns = 1; m_rc = 0; end
                    1: begin
                        if (!m_hf && m_lf) ns = 2;
                        else if (m_rc == ROT - 1) begin ns = 0; to = 1; end
                        else m_rc++;
                    end
                    2: begin
                        if (m_hf) begin ns = 1; m_rc = 0; end
                        else if (!m_lf) begin ns = 3; m_lc = 0; end
                    end
                    default: begin
                        if (m_hf) begin ns = 1; m_rc = 0; end
                        else if (m_lf) ns = 2;
                        else if (m_lc == LOST - 1) ns = 0;
                        else m_lc++;
                    end
                endcase
            end
            // filters after the FSM so the FSM sees the pre-edge filtered values
            if (h == m_hf) m_hcnt = 0;
            else if (m_hcnt == DEB - 1) begin m_hf = h; m_hcnt = 0; end
            else m_hcnt++;
            if (l == m_lf) m_lcnt = 0;
            else if (m_lcnt == DEB - 1) begin m_lf = l; m_lcnt = 0; end
            else m_lcnt++;
            if (to) m_rf = 1;
            else if (fc) m_rf = 0;
            m_st  = ns;
            e.est = 2'(ns);
            e.av  = en && (ns == 0 || ns == 2);
            e.gr  = en && (ns == 1);
            e.ge  = en && (ns == 3);
            e.rf  = m_rf;
        end
        sb_q.push_back(e);
    endtask

    // One clock: drive on the falling edge, compare the queued expectation after the rising edge.
    task automatic step(input bit rst, input bit en, input bit h, input bit l, input bit fc);
        exp_t e;
        @(negedge clock);
        reset       = rst;
        enable      = en;
        head        = h;
        left        = l;
        fault_clear = fc;
        model_edge(rst, en, h, l, fc);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'(1));
        end else begin
            e = sb_q.pop_front();
            chk("sb_estado",    32'(estado),    32'(e.est));
            chk("sb_avancar",   32'(avancar),   32'(e.av));
            chk("sb_girar",     32'(girar),     32'(e.gr));
            chk("sb_girar_esq", 32'(girar_esq), 32'(e.ge));
            chk("sb_rot_fault", 32'(rot_fault), 32'(e.rf));
            chk("sb_onehot", 32'(int'(avancar) + int'(girar) + int'(girar_esq) <= 1), 32'(1));
        end
    endtask

    task automatic run(input int n, input bit en, input bit h, input bit l);
        for (int i = 0; i < n; i++) step(0, en, h, l, 0);
    endtask

    initial begin
        bit r_h, r_l;
        reset = 1; enable = 0; head = 0; left = 0; fault_clear = 0;

        // reset and idle search
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("rst_estado", 32'(estado), 32'(0));
        chk("rst_avancar", 32'(avancar), 32'(0));
        chk("rst_fault", 32'(rot_fault), 32'(0));
        run(1, 1, 0, 0);
        chk("idle_avancar", 32'(avancar), 32'(1));
        chk("idle_estado", 32'(estado), 32'(0));
        run(9, 1, 0, 0);

        // glitch shorter than the debounce window is ignored
        run(3, 1, 1, 0);
        run(4, 1, 0, 0);
        chk("glitch_estado", 32'(estado), 32'(0));
        chk("glitch_girar", 32'(girar), 32'(0));

        // held head: filtered at edge 4, ROTATE at edge 5
        run(4, 1, 1, 0);
        chk("deb_edge4_estado", 32'(estado), 32'(0));
        run(1, 1, 1, 0);
        chk("rot_estado", 32'(estado), 32'(1));
        chk("rot_girar", 32'(girar), 32'(1));
        chk("rot_avancar", 32'(avancar), 32'(0));

        // wall found on the left
        run(4, 1, 0, 1);
        chk("fol_pre_estado", 32'(estado), 32'(1));
        run(1, 1, 0, 1);
        chk("fol_estado", 32'(estado), 32'(2));
        chk("fol_avancar", 32'(avancar), 32'(1));
        chk("fol_fault", 32'(rot_fault), 32'(0));

        // wall lost, recover, then lost timeout after 8 cycles
        run(5, 1, 0, 0);
        chk("rec_estado", 32'(estado), 32'(3));
        chk("rec_girar_esq", 32'(girar_esq), 32'(1));
        run(7, 1, 0, 0);
        chk("rec_hold_estado", 32'(estado), 32'(3));
        run(1, 1, 0, 0);
        chk("lost_to_estado", 32'(estado), 32'(0));
        chk("lost_to_avancar", 32'(avancar), 32'(1));

        // rotation timeout after 16 cycles sets the sticky fault
        run(5, 1, 1, 0);
        chk("to_rot_estado", 32'(estado), 32'(1));
        run(15, 1, 1, 0);
        chk("to_hold_estado", 32'(estado), 32'(1));
        chk("to_hold_fault", 32'(rot_fault), 32'(0));
        run(1, 1, 1, 0);
        chk("to_estado", 32'(estado), 32'(0));
        chk("to_fault", 32'(rot_fault), 32'(1));
        step(0, 1, 1, 0, 1);
        chk("clr_fault", 32'(rot_fault), 32'(0));
        chk("clr_estado", 32'(estado), 32'(1));
        run(15, 1, 1, 0);
        step(0, 1, 1, 0, 1);
        chk("setwins_fault", 32'(rot_fault), 32'(1));
        chk("setwins_estado", 32'(estado), 32'(0));

        // enable gating in FOLLOW
        step(1, 1, 0, 0, 0);
        run(5, 1, 1, 0);
        run(5, 1, 0, 1);
        chk("en_fol_estado", 32'(estado), 32'(2));
        run(1, 0, 0, 1);
        chk("dis_avancar", 32'(avancar), 32'(0));
        chk("dis_estado", 32'(estado), 32'(2));
        run(6, 0, 1, 1);
        chk("dis_frozen_estado", 32'(estado), 32'(2));
        chk("dis_girar", 32'(girar), 32'(0));
        run(1, 1, 1, 1);
        chk("reen_estado", 32'(estado), 32'(1));
        chk("reen_girar", 32'(girar), 32'(1));

        // reset in the middle of RECOVER, then a full-length recovery
        step(1, 1, 0, 0, 0);
        run(5, 1, 1, 0);
        run(5, 1, 0, 1);
        run(5, 1, 0, 0);
        chk("r2_rec_estado", 32'(estado), 32'(3));
        run(5, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("midrst_estado", 32'(estado), 32'(0));
        chk("midrst_girar_esq", 32'(girar_esq), 32'(0));
        chk("midrst_avancar", 32'(avancar), 32'(0));
        run(5, 1, 1, 0);
        run(5, 1, 0, 1);
        run(5, 1, 0, 0);
        chk("r3_rec_estado", 32'(estado), 32'(3));
        run(7, 1, 0, 0);
        chk("r3_hold_estado", 32'(estado), 32'(3));
        run(1, 1, 0, 0);
        chk("r3_to_estado", 32'(estado), 32'(0));

        // random traffic with slowly changing sensors, checked by the model
        r_h = 0;
        r_l = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) r_h = ~r_h;
            if ($urandom_range(0, 5) == 0) r_l = ~r_l;
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 15) != 0),
                 r_h, r_l, ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/robot_wall_follower.md
Name: robot_wall_follower

Overview:
- Next-generation left-wall-following controller for the robot platform.
- Debounces the raw `head` and `left` contact sensors over a parameterised window.
- Runs a four-state Moore machine (search, rotate, follow, recover) with cycle-count timeouts for rotation and lost-wall recovery.
- Drives registered motion commands to the motor stage.
- Adds over the previous controller: enable gating, a sticky rotation-fault flag, and a left-turn recovery mode.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a raw sensor must differ from its filtered value before the filtered value updates. Legal range ≥1.
- ROT_TIMEOUT, 16: maximum cycles in ROTATE before a fault is declared. Legal range ≥2.
- LOST_TIMEOUT, 8: maximum cycles in RECOVER before falling back to SEARCH. Legal range ≥2.
- CNT_W, 8: width of the debounce and timeout counters. Must hold max(DEBOUNCE_CYCLES, ROT_TIMEOUT, LOST_TIMEOUT).

Ports:
- clock  in  1  single system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run; 0 = freeze the FSM and stop the motors.
- head  in  1  raw front contact sensor.
- left  in  1  raw left contact sensor.
- fault_clear  in  1  clears rot_fault.
- avancar  out  1  drive forward (registered).
- girar  out  1  rotate right (registered).
- girar_esq  out  1  rotate left (registered).
- estado  out  2  current state: 00 SEARCH, 01 ROTATE, 10 FOLLOW, 11 RECOVER.
- rot_fault  out  1  sticky: a rotation timeout has occurred.

Behaviour:
- Reset (reset=1 at an edge):
  - estado=SEARCH.
  - Filtered sensors head_f and left_f = 0.
  - All counters = 0.
  - avancar=girar=girar_esq=0, rot_fault=0.
  - Reset has priority over every other input, including mid-rotation and mid-recovery.
- Debounce, per sensor, independent:
  - The counter increments while raw != filtered and clears to 0 when raw == filtered.
  - When the counter reaches DEBOUNCE_CYCLES-1 while raw != filtered, filtered takes the raw value at that edge and the counter clears.
  - A raw change held stable before edge 1 therefore updates filtered at edge DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
  - Filters run regardless of `enable`.
- FSM: transitions use head_f and left_f only, and are evaluated only when enable=1. With enable=0, state and timeout counters hold.
  - SEARCH: head_f=1 → ROTATE; otherwise stay.
  - ROTATE:
    - head_f=0 and left_f=1 → FOLLOW.
    - Else, if rot_cnt==ROT_TIMEOUT-1 → SEARCH and set rot_fault.
    - Else stay and increment rot_cnt.
    - The exit condition has priority over the timeout.
  - FOLLOW: head_f=1 → ROTATE; head_f=0 and left_f=0 → RECOVER; otherwise stay.
  - RECOVER:
    - head_f=1 → ROTATE.
    - Else, left_f=1 → FOLLOW.
    - Else, if lost_cnt==LOST_TIMEOUT-1 → SEARCH.
    - Else stay and increment lost_cnt.
  - rot_cnt clears on every entry to ROTATE. lost_cnt clears on every entry to RECOVER.
- Outputs:
  - Registered. On each non-reset edge they load the decode of the next state, gated by enable.
  - Decode: SEARCH → avancar=1. ROTATE → girar=1. FOLLOW → avancar=1. RECOVER → girar_esq=1.
  - enable=0 → all three motion outputs 0 at the next edge.
  - At most one motion output is 1 at any time.
  - estado equals the state register.
- Latency:
  - Raw sensor change → filtered: DEBOUNCE_CYCLES edges.
  - Filtered change → state and outputs: 1 further edge.
- rot_fault:
  - Set on a rotation timeout; cleared by fault_clear=1.
  - If set and clear coincide, set wins.
  - It does not affect motion.

Test Plan:
- Reset, enable=1, head=left=0 for 10 cycles → estado=00 and avancar=1 from the first edge after reset release; girar=girar_esq=0.
- head=1 pulsed for 3 cycles (DEBOUNCE_CYCLES=4) → head_f stays 0 and estado stays 00. Then head=1 held → head_f=1 at edge 4 after assertion, estado=01 and girar=1 at edge 5.
- In ROTATE, set head=0, left=1 (held) → FOLLOW with avancar=1 after 4+1 edges, rot_fault=0. Then drop left → estado=11, girar_esq=1. Keep both 0 for 8 more cycles → estado=00.
- In ROTATE, hold head=1 → after 16 cycles in ROTATE, estado=00 and rot_fault=1. Pulse fault_clear → rot_fault=0 next edge. Also drive fault_clear=1 on the timeout edge → rot_fault=1 (set wins).
- In FOLLOW, drop enable → all motion outputs 0 and estado frozen, including while head_f changes. Re-enable → transition evaluated on the next edge.
- Assert reset for 1 cycle mid-RECOVER with lost_cnt=5 → estado=00, outputs 0, counters 0. Next RECOVER entry takes the full 8 cycles to time out.
